// File: rtl/booth_pkg.sv
// Shared types and width helpers for the radix-4 Booth multiplier.
//   state_e : controller states
//   op_e    : partial-product selection produced by the recoder
//   steps_for / acc_w_for : iteration count and accumulator width for a
//                           given operand width
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } op_e;

    // Operands are extended to W+2 bits, giving (W+2)/2 Booth triplets.
    function automatic int steps_for(input int w);
        return w / 2 + 1;
    endfunction

    // Headroom for +/-2M on top of a W+2 bit running sum.
    function automatic int acc_w_for(input int w);
        return w + 4;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder (combinational).
//   triplet : {Q[1], Q[0], q_m1}
//   op      : partial product to add this step (0, +M, +2M, -M, -2M)
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output op_e        op
);

    always_comb begin
        op = ZERO;
        case (triplet)
            3'b001, 3'b010: op = PM;
            3'b011:         op = P2M;
            3'b100:         op = N2M;
            3'b101, 3'b110: op = NM;
            default:        op = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential signed/unsigned multiplier, radix-4 Booth, with built-in
// controller and start/ready/valid handshake.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request; accepted when ready=1
//   mode_signed   : 1 = two's complement operands, sampled with start
//   a, b          : multiplicand / multiplier, sampled on accept
//   ready         : can accept start (IDLE or DONE)
//   busy          : iterating (CALC)
//   valid         : one-cycle pulse when product is updated
//   product       : 2W-bit result, held until the next completion
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one Booth step per cycle, cnt counts remaining steps
// DONE  | result published (valid=1); may accept the next start
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode_signed,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           valid,
    output logic [2*W-1:0] product
);

    localparam int STEPS = steps_for(W);
    localparam int ACC_W = acc_w_for(W);
    localparam int QW    = W + 2;
    localparam int CNT_W = $clog2(STEPS + 1);

    if ((W % 2) != 0 || W < 4) begin : g_bad_width
        $error("booth_r4_multiplier: W must be even and at least 4");
    end

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [QW-1:0]      q_q, q_d;
    logic [QW-1:0]      m_q, m_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     product_q, product_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    op_e                op;
    logic [ACC_W-1:0]   m_acc, m2_acc, op_val, sum, acc_sh;
    logic [QW-1:0]      q_sh;

    booth_r4_recoder u_recoder (
        .triplet ({q_q[1:0], qm1_q}),
        .op      (op)
    );

    // Step datapath: add the selected partial product, then shift
    // {acc,Q,q_m1} right by two with the sum's sign replicated.
    always_comb begin
        m_acc  = {{2{m_q[QW-1]}}, m_q};
        m2_acc = {m_q[QW-1], m_q, 1'b0};
        op_val = '0;
        case (op)
            PM:      op_val = m_acc;
            P2M:     op_val = m2_acc;
            NM:      op_val = -m_acc;
            N2M:     op_val = -m2_acc;
            default: op_val = '0;
        endcase
        sum    = acc_q + op_val;
        acc_sh = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
        q_sh   = {sum[1:0], q_q[QW-1:2]};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    m_d     = mode_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
                    q_d     = mode_signed ? {{2{b[W-1]}}, b} : {2'b00, b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CNT_W'(STEPS);
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                qm1_d = q_q[1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    product_d = {acc_sh[W-3:0], q_sh};
                    valid_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != CALC);
        busy_d  = (state_d == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign product = product_q;

endmodule
